snake_cmd_scheduler: RTL and testbench

//  Sole source of the 7-bit command stream into the snake game core.
//  Two requesters share one command FIFO under round-robin arbitration:
//  - HPS writes over an Avalon-MM slave.
//  - Falling edges on the DE1 pushbuttons.

---
 rtl/snake_cmd_scheduler.sv | 262 ++++++++++++++++++++++++++
 tb/tb_snake_cmd_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_cmd_scheduler.sv
// snake_cmd_scheduler
// Merges HPS (Avalon-MM) commands and debounced-edge pushbutton commands into
// one command FIFO under round-robin arbitration, and generates the periodic
// STEP tick. STEP has output priority over queued commands. The command
// stream leaves through a valid/ready interface, one command per two cycles
// at most.
module snake_cmd_scheduler #(
    parameter int TICK_DIV   = 2500000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    input  logic [3:0]  key_n,
    output logic [6:0]  cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [6:0] CMD_UP    = 7'h01;
    localparam logic [6:0] CMD_DOWN  = 7'h02;
    localparam logic [6:0] CMD_LEFT  = 7'h04;
    localparam logic [6:0] CMD_RIGHT = 7'h08;
    localparam logic [6:0] CMD_STEP  = 7'h40;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t state;

    // Key path
    logic [3:0] key_s1, key_s2, key_prev;
    logic [3:0] key_fall;
    logic       key_new_valid;
    logic       key_multi;
    logic [6:0] key_new_cmd;
    logic       key_hold_valid;
    logic [6:0] key_hold_cmd;

    // Arbitration
    logic       rr_key_pri;
    logic       key_req;
    logic [6:0] key_req_cmd;
    logic       hps_req;
    logic       ctrl_wr;
    logic       grant_key;
    logic       grant_hps;
    logic       key_to_hold;
    logic       push;
    logic [6:0] push_data;
    logic       pop;
    logic       flush;
    logic       flag_clr;
    logic       ovf_set;

    // FIFO
    logic [6:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;

    // Control / status
    logic              enable;
    logic              overflow;
    logic              tick_overrun;
    logic              tick_pending;
    logic              tick_wrap;
    logic              tick_take;
    logic [TICK_W-1:0] tick_cnt;
    logic [31:0]       status_word;

    // Only writedata[6:0] carries information; the upper bits are ignored.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:7];

    // Two-flop synchronizer on the raw pins plus a delayed copy for edge detect.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples the pre-edge value of its source, independent of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_s1   <= 4'hF;
            key_s2   <= 4'hF;
            key_prev <= 4'hF;
        end else begin
            key_s1   <= key_n;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    // Press detection, requester selection, arbitration and flag events.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        key_fall      = key_prev & ~key_s2;
        key_new_valid = |key_fall;
        key_multi     = (key_fall & (key_fall - 4'd1)) != 4'd0;
        key_new_cmd   = CMD_UP;
        if (key_fall[0])      key_new_cmd = CMD_RIGHT;
        else if (key_fall[1]) key_new_cmd = CMD_LEFT;
        else if (key_fall[2]) key_new_cmd = CMD_DOWN;

        key_req     = key_hold_valid | key_new_valid;
        key_req_cmd = key_hold_valid ? key_hold_cmd : key_new_cmd;
        hps_req     = avs_write && !avs_address && (avs_writedata[6:0] != 7'd0);
        ctrl_wr     = avs_write && avs_address;
        flush       = ctrl_wr && avs_writedata[2];
        flag_clr    = ctrl_wr && avs_writedata[1];
        fifo_full   = (fifo_count == FIFO_FULL);

        grant_key   = key_req && !fifo_full && (!hps_req || rr_key_pri);
        grant_hps   = hps_req && !fifo_full && (!key_req || !rr_key_pri);
        key_to_hold = key_req && hps_req && !fifo_full && !rr_key_pri;

        push        = grant_key || grant_hps;
        push_data   = grant_key ? key_req_cmd : avs_writedata[6:0];
        pop         = (state == IDLE) && !tick_pending && (fifo_count != '0);

        // Dropped key requests: extra simultaneous presses, a new press while
        // key_hold is occupied, or any key request meeting a full FIFO.
        ovf_set     = key_multi || (key_hold_valid && key_new_valid) || (key_req && fifo_full);

        // HPS is never dropped: it stalls until granted.
        avs_waitrequest = hps_req && !grant_hps;

        tick_wrap   = enable && (tick_cnt == TICK_LAST);
        tick_take   = (state == IDLE) && tick_pending;

        status_word = {16'd0, 6'(fifo_count), 1'b0, cmd_valid, 5'd0,
                       tick_overrun, overflow, enable};
    end

    // Key_hold parks a key request that lost arbitration to the HPS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_hold_valid <= 1'b0;
            key_hold_cmd   <= 7'd0;
        end else if (flush) begin
            key_hold_valid <= 1'b0;
        end else if (key_to_hold) begin
            key_hold_valid <= 1'b1;
            key_hold_cmd   <= key_req_cmd;
        end else if (grant_key || (key_req && fifo_full)) begin
            key_hold_valid <= 1'b0;
        end
    end

    // Round-robin pointer: only a contested decision flips the priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_key_pri <= 1'b1;
        end else if (key_req && hps_req && !fifo_full) begin
            rr_key_pri <= ~rr_key_pri;
        end
    end

    // FIFO storage.
    // NOTE: the storage array has no reset; validity is carried entirely by
    // the pointers and count, which keeps the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy; a flush overrides a simultaneous push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Tick counter: runs 0..TICK_DIV-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (!enable || tick_wrap) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Control register and sticky flags; a new event beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable       <= 1'b0;
            overflow     <= 1'b0;
            tick_overrun <= 1'b0;
            tick_pending <= 1'b0;
        end else begin
            if (ctrl_wr) enable <= avs_writedata[0];
            overflow     <= (overflow && !flag_clr) || ovf_set;
            tick_overrun <= (tick_overrun && !flag_clr) || (tick_wrap && tick_pending);
            tick_pending <= (tick_pending && !tick_take) || tick_wrap;
        end
    end

    // Output FSM: load STEP or the FIFO head in IDLE, hold it in PRESENT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_data  <= 7'd0;
            cmd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick_pending) begin
                        cmd_data  <= CMD_STEP;
                        cmd_valid <= 1'b1;
                        state     <= PRESENT;
                    end else if (fifo_count != '0) begin
                        cmd_data  <= fifo_mem[rd_ptr];
                        cmd_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered read port, updated only on a read strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= 32'd0;
        end else if (avs_read) begin
            avs_readdata <= avs_address ? status_word : {25'd0, cmd_data};
        end
    end

endmodule

// File: tb/tb_snake_cmd_scheduler.sv
// Testbench for snake_cmd_scheduler: directed scenarios followed by a random
// phase. A behavioural model predicts every loaded command, read value,
// waitrequest and cmd_valid; a separate monitor compares on the falling edge.
module tb_snake_cmd_scheduler;

    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 4;
    localparam logic [6:0] STEP = 7'h40;

    logic        clk;
    logic        reset_n;
    logic        avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [3:0]  key_n;
    logic [6:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    snake_cmd_scheduler #(
        .TICK_DIV   (TICK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .key_n           (key_n),
        .cmd_data        (cmd_data),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0]  m_fifo [$];
    logic [6:0]  exp_cmd_q [$];
    logic [31:0] exp_rd_q [$];
    logic [3:0]  m_h0, m_h1, m_h2;   // pin samples from the last three edges
    bit          m_hold_v;
    logic [6:0]  m_hold;
    bit          m_key_first;
    bit          m_en, m_ovf, m_ovr, m_tp, m_pv;
    int          m_cnt;
    logic [6:0]  m_last;

    function automatic logic [6:0] key_map(input int idx);
        case (idx)
            0:       return 7'h08;
            1:       return 7'h04;
            2:       return 7'h02;
            default: return 7'h01;
        endcase
    endfunction

    task automatic m_reset();
        m_fifo.delete();
        exp_cmd_q.delete();
        exp_rd_q.delete();
        m_h0 = 4'hF; m_h1 = 4'hF; m_h2 = 4'hF;
        m_hold_v = 0; m_hold = 7'd0;
        m_key_first = 1;
        m_en = 0; m_ovf = 0; m_ovr = 0; m_tp = 0; m_pv = 0;
        m_cnt = 0;
        m_last = 7'd0;
    endtask

    // A press is a pin seen high then low, acted on two edges later.
    function automatic logic [3:0] m_presses();
        return m_h2 & ~m_h1;
    endfunction

    function automatic bit m_hps_req();
        return avs_write && !avs_address && (avs_writedata[6:0] != 7'd0);
    endfunction

    function automatic bit m_wait();
        bit key_req;
        key_req = m_hold_v || (m_presses() != 4'd0);
        return m_hps_req() && ((m_fifo.size() >= DEPTH) || (key_req && m_key_first));
    endfunction

    task automatic m_step();
        logic [3:0] presses;
        bit         new_v, key_req, hps_req, full, ovf_set, wrap, take, ovr_set, clr, flush;
        logic [6:0] new_cmd, key_cmd;
        presses = m_presses();
        ovf_set = 0; wrap = 0; take = 0; ovr_set = 0;
        new_v   = presses != 4'd0;
        new_cmd = 7'd0;
        for (int i = 3; i >= 0; i--) if (presses[i]) new_cmd = key_map(i);
        if ($countones(presses) > 1) ovf_set = 1;
        if (m_hold_v && new_v) ovf_set = 1;
        key_req = m_hold_v || new_v;
        key_cmd = m_hold_v ? m_hold : new_cmd;
        hps_req = m_hps_req();
        full    = m_fifo.size() >= DEPTH;

        if (avs_read)
            exp_rd_q.push_back(avs_address ?
                {16'd0, 6'(m_fifo.size()), 1'b0, m_pv, 5'd0, m_ovr, m_ovf, m_en} :
                {25'd0, m_last});

        // Output side sees the queue as it was before this edge's push.
        if (!m_pv) begin
            if (m_tp) begin
                m_last = STEP; m_pv = 1; take = 1;
                exp_cmd_q.push_back(STEP);
            end else if (m_fifo.size() > 0) begin
                m_last = m_fifo.pop_front(); m_pv = 1;
                exp_cmd_q.push_back(m_last);
            end
        end else if (cmd_ready) begin
            m_pv = 0;
        end

        if (full) begin
            if (key_req) begin ovf_set = 1; m_hold_v = 0; end
        end else if (key_req && hps_req) begin
            if (m_key_first) begin
                m_fifo.push_back(key_cmd); m_hold_v = 0;
            end else begin
                m_fifo.push_back(avs_writedata[6:0]); m_hold_v = 1; m_hold = key_cmd;
            end
            m_key_first = !m_key_first;
        end else if (key_req) begin
            m_fifo.push_back(key_cmd); m_hold_v = 0;
        end else if (hps_req) begin
            m_fifo.push_back(avs_writedata[6:0]);
        end

        if (m_en) begin
            if (m_cnt == TICK_DIV - 1) begin m_cnt = 0; wrap = 1; end
            else m_cnt++;
        end else begin
            m_cnt = 0;
        end
        if (wrap && m_tp) ovr_set = 1;
        m_tp = (m_tp && !take) || wrap;

        clr   = avs_write && avs_address && avs_writedata[1];
        flush = avs_write && avs_address && avs_writedata[2];
        if (avs_write && avs_address) m_en = avs_writedata[0];
        if (flush) begin m_fifo.delete(); m_hold_v = 0; end
        m_ovf = (m_ovf && !clr) || ovf_set;
        m_ovr = (m_ovr && !clr) || ovr_set;

        m_h2 = m_h1; m_h1 = m_h0; m_h0 = key_n;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_reset();
        else          m_step();
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            check("cmd_valid", 32'(cmd_valid), 32'(m_pv));
            check("waitrequest", 32'(avs_waitrequest), 32'(m_wait()));
            if (exp_rd_q.size() > 0)
                check("readdata", avs_readdata, exp_rd_q.pop_front());
            if (cmd_valid) begin
                if (exp_cmd_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL cmd_unexpected: got 0x%0h, expected no command at %0t", cmd_data, $time);
                end else begin
                    check("cmd_data", 32'(cmd_data), 32'(exp_cmd_q[0]));
                    if (cmd_ready) void'(exp_cmd_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        key_n = 4'hF; avs_write = 0; avs_read = 0; cmd_ready = 0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    // Holds the write until accepted; gives up after a bounded stall.
    task automatic avs_wr(input logic addr, input logic [31:0] data);
        bit done;
        done = 0;
        avs_address = addr; avs_writedata = data; avs_write = 1; avs_read = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = !avs_waitrequest;
            @(posedge clk); #1;
        end
        avs_write = 0;
    endtask

    task automatic avs_rd(input logic addr);
        avs_address = addr; avs_read = 1; avs_write = 0;
        step_cycle();
        avs_read = 0;
    endtask

    task automatic press(input int k, input int cycles);
        key_n[k] = 1'b0;
        repeat (cycles) step_cycle();
        key_n[k] = 1'b1;
        repeat (3) step_cycle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n = 0; key_n = 4'hF; cmd_ready = 0;
        avs_address = 0; avs_write = 0; avs_writedata = 32'd0; avs_read = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_cmd_data", 32'(cmd_data), 32'd0);
        check("reset_readdata", avs_readdata, 32'd0);
        check("reset_waitrequest", 32'(avs_waitrequest), 32'd0);
        reset_n = 1;
        step_cycle();

        // 1: single HPS command with ready high, then status and last command.
        cmd_ready = 1;
        avs_wr(1'b0, 32'h04);
        repeat (4) step_cycle();
        avs_rd(1'b1);
        avs_rd(1'b0);
        step_cycle();

        // 2: key3 press collides with an HPS write right after reset.
        do_reset();
        cmd_ready = 1;
        key_n[3] = 1'b0;
        step_cycle();
        step_cycle();
        avs_wr(1'b0, 32'h08);
        repeat (6) step_cycle();
        key_n[3] = 1'b1;
        repeat (4) step_cycle();

        // 3: fill the FIFO with ready low, stall the 6th write, drop key presses.
        do_reset();
        cmd_ready = 0;
        for (int i = 0; i < 6; i++) avs_wr(1'b0, 32'(7'h01 << i));
        press(0, 4);
        press(1, 4);
        avs_rd(1'b1);
        avs_wr(1'b1, 32'h2);
        avs_rd(1'b1);
        cmd_ready = 1;
        repeat (14) step_cycle();
        avs_rd(1'b1);

        // 4: periodic STEP, overrun while stalled, flag clear.
        do_reset();
        cmd_ready = 1;
        avs_wr(1'b1, 32'h1);
        repeat (20) step_cycle();
        cmd_ready = 0;
        repeat (10) step_cycle();
        avs_rd(1'b1);
        cmd_ready = 1;
        step_cycle();
        avs_wr(1'b1, 32'h3);
        avs_rd(1'b1);
        avs_wr(1'b1, 32'h0);
        repeat (6) step_cycle();

        // 5: STEP pending and FIFO non-empty at the same IDLE edge.
        do_reset();
        cmd_ready = 0;
        avs_wr(1'b0, 32'h01);
        avs_wr(1'b0, 32'h02);
        avs_wr(1'b1, 32'h1);
        repeat (6) step_cycle();
        avs_wr(1'b1, 32'h0);
        cmd_ready = 1;
        repeat (10) step_cycle();

        // 6: asynchronous reset while presenting.
        do_reset();
        cmd_ready = 0;
        avs_wr(1'b0, 32'h02);
        step_cycle();
        check("present_before_reset", 32'(cmd_valid), 32'd1);
        avs_wr(1'b0, 32'h04);
        #2 reset_n = 0;
        #1 check("async_reset_cmd_valid", 32'(cmd_valid), 32'd0);
        @(posedge clk); #1;
        reset_n = 1;
        avs_rd(1'b1);
        cmd_ready = 1;
        repeat (4) step_cycle();

        // Random phase.
        do_reset();
        begin
            int stall_cnt;
            stall_cnt = 0;
            for (int i = 0; i < 3000; i++) begin
                bit hold_wr;
                int r;
                @(negedge clk);
                hold_wr = avs_write && avs_waitrequest && (stall_cnt < 30);
                @(posedge clk); #1;
                if (hold_wr) begin
                    stall_cnt++;
                end else begin
                    stall_cnt = 0;
                    avs_write = 0; avs_read = 0;
                    r = $urandom_range(0, 99);
                    if (r < 25) begin
                        avs_write = 1; avs_address = 0; avs_writedata = $urandom;
                        if ($urandom_range(0, 7) == 0) avs_writedata[6:0] = 7'd0;
                    end else if (r < 29) begin
                        avs_write = 1; avs_address = 1;
                        avs_writedata = 32'($urandom_range(0, 7));
                        avs_writedata[0] = ($urandom_range(0, 3) != 0);
                    end else if (r < 45) begin
                        avs_read = 1; avs_address = 1'($urandom_range(0, 1));
                    end
                end
                cmd_ready = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 19) == 0) key_n[k] = ~key_n[k];
            end
        end
        avs_write = 0; avs_read = 0; key_n = 4'hF;
        step_cycle();
        avs_wr(1'b1, 32'h0);
        cmd_ready = 1;
        repeat (40) step_cycle();
        avs_rd(1'b1);
        step_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
